// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RISC-V core: registers the decode word for EX,
// detects load-use hazards, inserts bubbles on stalls/flushes and counts both events.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [PC_W-1:0]   id_pc,
    input  logic [31:0]       id_instr,
    input  logic              id_alusrc,
    input  logic              id_memtoreg,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_branch,
    input  logic [1:0]        id_aluop,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              branch_taken,
    output logic              stall,
    output logic              ex_valid,
    output logic [PC_W-1:0]   ex_pc,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,
    output logic              ex_alusrc,
    output logic              ex_memtoreg,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_branch,
    output logic [1:0]        ex_aluop,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [6:0] opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       haz;
    logic       load_word;

    assign opcode = id_instr[6:0];
    assign id_rs1 = id_instr[19:15];
    assign id_rs2 = id_instr[24:20];

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_R, OP_STORE, OP_BRANCH: begin
                uses_rs1 = id_valid;
                uses_rs2 = id_valid;
            end
            OP_LOAD, OP_IMM: uses_rs1 = id_valid;
            default: ;
        endcase
    end

    // A load in EX whose destination feeds a source actually read by ID; x0 never hazards.
    assign haz = ex_valid & ex_memread & (ex_rd != 5'd0) &
                 ((uses_rs1 & (ex_rd == id_rs1)) | (uses_rs2 & (ex_rd == id_rs2)));
    assign stall     = haz & ~branch_taken;
    assign load_word = id_valid & ~branch_taken & ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_funct7   <= '0;
            ex_alusrc   <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_aluop    <= '0;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
            ex_imm      <= '0;
        end else begin
            // Bubbles only clear the control word; data fields keep stale contents.
            ex_valid    <= load_word;
            ex_alusrc   <= load_word & id_alusrc;
            ex_memtoreg <= load_word & id_memtoreg;
            ex_regwrite <= load_word & id_regwrite;
            ex_memread  <= load_word & id_memread;
            ex_memwrite <= load_word & id_memwrite;
            ex_branch   <= load_word & id_branch;
            ex_aluop    <= load_word ? id_aluop : 2'b00;
            if (load_word) begin
                ex_pc     <= id_pc;
                ex_rs1    <= id_rs1;
                ex_rs2    <= id_rs2;
                ex_rd     <= id_instr[11:7];
                ex_funct3 <= id_instr[14:12];
                ex_funct7 <= id_instr[31:25];
                ex_rd1    <= id_rd1;
                ex_rd2    <= id_rd2;
                ex_imm    <= id_imm;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + 1'b1;
            end
            if (branch_taken && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed load-use/flush cases then random traffic,
// with a second CNT_W=2 instance sharing the stimulus to exercise counter saturation.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int PC_W   = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic id_valid = 1'b0;
    logic [PC_W-1:0] id_pc = '0;
    logic [31:0] id_instr = '0;
    logic id_alusrc = 1'b0, id_memtoreg = 1'b0, id_regwrite = 1'b0;
    logic id_memread = 1'b0, id_memwrite = 1'b0, id_branch = 1'b0;
    logic [1:0] id_aluop = '0;
    logic [DATA_W-1:0] id_rd1 = '0, id_rd2 = '0, id_imm = '0;
    logic branch_taken = 1'b0;

    logic stall, ex_valid;
    logic [PC_W-1:0] ex_pc;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [2:0] ex_funct3;
    logic [6:0] ex_funct7;
    logic ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
    logic [1:0] ex_aluop;
    logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm;
    logic [15:0] stall_count, flush_count;

    logic s_stall, s_ex_valid;
    logic [PC_W-1:0] s_ex_pc;
    logic [4:0] s_ex_rs1, s_ex_rs2, s_ex_rd;
    logic [2:0] s_ex_funct3;
    logic [6:0] s_ex_funct7;
    logic s_ex_alusrc, s_ex_memtoreg, s_ex_regwrite, s_ex_memread, s_ex_memwrite, s_ex_branch;
    logic [1:0] s_ex_aluop;
    logic [DATA_W-1:0] s_ex_rd1, s_ex_rd2, s_ex_imm;
    logic [1:0] s_stall_count, s_flush_count;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
        .id_aluop(id_aluop), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .branch_taken(branch_taken), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7(ex_funct7), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_branch(ex_branch), .ex_aluop(ex_aluop), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .stall_count(stall_count), .flush_count(flush_count)
    );

    id_ex_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
        .id_aluop(id_aluop), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .branch_taken(branch_taken), .stall(s_stall), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc),
        .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd), .ex_funct3(s_ex_funct3),
        .ex_funct7(s_ex_funct7), .ex_alusrc(s_ex_alusrc), .ex_memtoreg(s_ex_memtoreg),
        .ex_regwrite(s_ex_regwrite), .ex_memread(s_ex_memread), .ex_memwrite(s_ex_memwrite),
        .ex_branch(s_ex_branch), .ex_aluop(s_ex_aluop), .ex_rd1(s_ex_rd1), .ex_rd2(s_ex_rd2),
        .ex_imm(s_ex_imm), .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    typedef struct {
        bit        in_reset;
        bit        stall;
        bit        valid;
        bit [7:0]  ctrl;
        bit [8:0]  pc;
        bit [31:0] instr;
        bit [31:0] rd1;
        bit [31:0] rd2;
        bit [31:0] imm;
        int        sc;
        int        fc;
        int        ssc;
        int        sfc;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state: what EX should hold, plus event counts.
    bit        m_valid;
    bit [7:0]  m_ctrl;
    bit [8:0]  m_pc;
    bit [31:0] m_instr, m_rd1, m_rd2, m_imm;
    int        m_sc, m_fc, m_ssc, m_sfc;
    bit        last_stall;

    localparam bit [6:0] OP_R = 7'b0110011, OP_L = 7'b0000011, OP_S = 7'b0100011;
    localparam bit [6:0] OP_B = 7'b1100011, OP_I = 7'b0010011, OP_U = 7'b0110111;

    // Main-controller table: {alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop}.
    function automatic bit [7:0] ctrl_for(input bit [6:0] op);
        case (op)
            OP_R:    return 8'b0010_0010;
            OP_L:    return 8'b1111_0000;
            OP_S:    return 8'b1000_1000;
            OP_B:    return 8'b0000_0101;
            OP_I:    return 8'b1010_0010;
            default: return 8'b1010_0000;
        endcase
    endfunction

    function automatic bit [31:0] mk(input bit [6:0] op, input int rd, input int rs1,
                                     input int rs2, input bit [2:0] f3, input bit [6:0] f7);
        return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], op};
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit valid, input bit [31:0] instr,
                                 input bit [8:0] pc, input bit [31:0] rd1, input bit [31:0] rd2,
                                 input bit [31:0] imm, input bit bt);
        exp_t e;
        bit [7:0] c;
        bit [6:0] op;
        bit u1, u2, haz, st;
        c  = ctrl_for(instr[6:0]);
        op = instr[6:0];
        @(negedge clk);
        reset = rst;
        id_valid = valid; id_instr = instr; id_pc = pc;
        {id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_aluop} = c;
        id_rd1 = rd1; id_rd2 = rd2; id_imm = imm; branch_taken = bt;
        e = '{default: 0};
        if (rst) begin
            m_valid = 0; m_ctrl = 0; m_pc = 0; m_instr = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
            m_sc = 0; m_fc = 0; m_ssc = 0; m_sfc = 0;
            st = 0;
            e.in_reset = 1;
        end else begin
            u1  = valid && (op inside {OP_R, OP_L, OP_S, OP_B, OP_I});
            u2  = valid && (op inside {OP_R, OP_S, OP_B});
            haz = m_valid && m_ctrl[4] && (m_instr[11:7] != 0) &&
                  ((u1 && m_instr[11:7] == instr[19:15]) || (u2 && m_instr[11:7] == instr[24:20]));
            st  = haz && !bt;
            if (st) begin
                m_sc  = (m_sc < 65535) ? m_sc + 1 : m_sc;
                m_ssc = (m_ssc < 3) ? m_ssc + 1 : m_ssc;
            end
            if (bt) begin
                m_fc  = (m_fc < 65535) ? m_fc + 1 : m_fc;
                m_sfc = (m_sfc < 3) ? m_sfc + 1 : m_sfc;
            end
            if (bt || st || !valid) begin
                m_valid = 0; m_ctrl = 0;
            end else begin
                m_valid = 1; m_ctrl = c; m_pc = pc; m_instr = instr;
                m_rd1 = rd1; m_rd2 = rd2; m_imm = imm;
            end
        end
        last_stall = st;
        e.stall = st; e.valid = m_valid; e.ctrl = m_ctrl; e.pc = m_pc; e.instr = m_instr;
        e.rd1 = m_rd1; e.rd2 = m_rd2; e.imm = m_imm;
        e.sc = m_sc; e.fc = m_fc; e.ssc = m_ssc; e.sfc = m_sfc;
        exp_q.push_back(e);
    endtask

    // Monitor: stall is sampled mid-cycle, the registered word just after the edge.
    initial begin
        exp_t e;
        bit act_stall, act_sstall;
        forever begin
            @(negedge clk);
            #2;
            act_stall  = stall;
            act_sstall = s_stall;
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard_empty: got 0 entries, required 1 at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                checkOutput("stall", act_stall, e.stall);
                checkOutput("stall_small", act_sstall, e.stall);
                checkOutput("ex_valid", ex_valid, e.valid);
                checkOutput("ctrl", {ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
                                     ex_memwrite, ex_branch, ex_aluop}, e.ctrl);
                checkOutput("stall_count", stall_count, e.sc);
                checkOutput("flush_count", flush_count, e.fc);
                checkOutput("stall_count_sat", s_stall_count, e.ssc);
                checkOutput("flush_count_sat", s_flush_count, e.sfc);
                if (e.valid || e.in_reset) begin
                    checkOutput("ex_pc", ex_pc, e.pc);
                    checkOutput("ex_rs1", ex_rs1, e.instr[19:15]);
                    checkOutput("ex_rs2", ex_rs2, e.instr[24:20]);
                    checkOutput("ex_rd", ex_rd, e.instr[11:7]);
                    checkOutput("ex_funct3", ex_funct3, e.instr[14:12]);
                    checkOutput("ex_funct7", ex_funct7, e.instr[31:25]);
                    checkOutput("ex_rd1", ex_rd1, e.rd1);
                    checkOutput("ex_rd2", ex_rd2, e.rd2);
                    checkOutput("ex_imm", ex_imm, e.imm);
                end
            end
        end
    end

    initial begin
        bit [6:0]  ops [6];
        bit        r_valid, r_bt;
        bit [31:0] r_instr, r_rd1, r_rd2, r_imm;
        bit [8:0]  r_pc;
        ops = '{OP_R, OP_L, OP_S, OP_B, OP_I, OP_U};

        // Reset with random inputs on the ID side.
        repeat (2) applyStimulus(1, 1, $urandom, 9'($urandom), $urandom, $urandom, $urandom, 1'($urandom));

        // ADDI x5,x1,3 with nothing in EX.
        applyStimulus(0, 1, mk(OP_I, 5, 1, 3, 0, 0), 9'h10, 32'h11, 32'h22, 32'd3, 0);
        // LW x6 then dependent ADD x7,x6,x2: stall, then re-presented ADD loads.
        applyStimulus(0, 1, mk(OP_L, 6, 1, 0, 3'b010, 0), 9'h14, 32'h100, 32'h0, 32'd8, 0);
        applyStimulus(0, 1, mk(OP_R, 7, 6, 2, 0, 0), 9'h18, 32'h5, 32'h6, 32'h0, 0);
        applyStimulus(0, 1, mk(OP_R, 7, 6, 2, 0, 0), 9'h18, 32'h5, 32'h6, 32'h0, 0);
        // LW x0 followed by reader of x0: no stall.
        applyStimulus(0, 1, mk(OP_L, 0, 1, 0, 3'b010, 0), 9'h1c, 32'h1, 32'h2, 32'd4, 0);
        applyStimulus(0, 1, mk(OP_R, 7, 0, 0, 0, 0), 9'h20, 32'h3, 32'h4, 32'h0, 0);
        // LW x6 followed by ADDI whose imm field aliases rs2=6: no stall.
        applyStimulus(0, 1, mk(OP_L, 6, 1, 0, 3'b010, 0), 9'h24, 32'h1, 32'h2, 32'd4, 0);
        applyStimulus(0, 1, mk(OP_I, 8, 1, 6, 0, 0), 9'h28, 32'h1, 32'h2, 32'd6, 0);
        // Load-use with a taken branch: flush wins over stall.
        applyStimulus(0, 1, mk(OP_L, 6, 1, 0, 3'b010, 0), 9'h2c, 32'h1, 32'h2, 32'd4, 0);
        applyStimulus(0, 1, mk(OP_R, 7, 6, 2, 0, 0), 9'h30, 32'h5, 32'h6, 32'h0, 1);
        // Five load-use pairs push the narrow stall counter into saturation.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1, mk(OP_L, 6, 1, 0, 3'b010, 0), 9'h40, 32'h1, 32'h2, 32'd4, 0);
            applyStimulus(0, 1, mk(OP_S, 0, 6, 6, 3'b010, 0), 9'h44, 32'h7, 32'h8, 32'd0, 0);
            applyStimulus(0, 1, mk(OP_S, 0, 6, 6, 3'b010, 0), 9'h44, 32'h7, 32'h8, 32'd0, 0);
        end

        // Random traffic on a narrow register window so hazards are frequent.
        r_valid = 0; r_instr = 0; r_pc = 0; r_rd1 = 0; r_rd2 = 0; r_imm = 0;
        for (int n = 0; n < 400; n++) begin
            if (!last_stall) begin
                r_valid = ($urandom_range(0, 7) != 0);
                r_instr = mk(ops[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3),
                             $urandom_range(0, 3), 3'($urandom), 7'($urandom));
                r_pc = 9'($urandom); r_rd1 = $urandom; r_rd2 = $urandom; r_imm = $urandom;
            end
            r_bt = ($urandom_range(0, 7) == 0);
            applyStimulus((n == 200), r_valid, r_instr, r_pc, r_rd1, r_rd2, r_imm, r_bt);
        end

        @(posedge clk);
        #3;
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
